// File: rtl/ts_pkg.sv
// Shared constants, state type and sync-byte helper for the TS packet aligner.
package ts_pkg;

  localparam logic [7:0] TS_SYNC_BYTE      = 8'h47;
  localparam logic [7:0] PACK_BYTE_SIZE    = 8'd188;
  localparam logic [7:0] PACK_RS_BYTE_SIZE = 8'd204;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } ts_state_t;

  function automatic logic is_sync(input logic [7:0] b);
    return (b == TS_SYNC_BYTE);
  endfunction

endpackage

// File: rtl/ts_align_stats.sv
// Statistics for the TS aligner: forwarded packet count (wrapping) and
// LOCKED->HUNT transition count (saturating). A clear beats any increment.
module ts_align_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        pkt_inc,
  input  logic        loss_inc,
  output logic [31:0] packet_count,
  output logic [15:0] sync_loss_count
);

  // Packet counter, free-running wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      packet_count <= 32'd0;
    end else if (clear) begin
      packet_count <= 32'd0;
    end else if (pkt_inc) begin
      packet_count <= packet_count + 32'd1;
    end else begin
      packet_count <= packet_count;
    end
  end

  // Sync-loss counter, sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_loss_count <= 16'd0;
    end else if (clear) begin
      sync_loss_count <= 16'd0;
    end else if (loss_inc && (sync_loss_count != 16'hFFFF)) begin
      sync_loss_count <= sync_loss_count + 16'd1;
    end else begin
      sync_loss_count <= sync_loss_count;
    end
  end

endmodule

// File: rtl/ts_packet_aligner.sv
// TS packet aligner: hunts for 0x47, verifies lock, flywheels through sync errors.
// Defining TS_ALIGN_204_EN adds 204-byte (RS parity) framing with parity bytes dropped.
module ts_packet_aligner
  import ts_pkg::*;
#(
  parameter int LOCK_COUNT   = 3,
  parameter int UNLOCK_COUNT = 3
) (
  input  logic        mpeg_clk,
  input  logic        S_AXI_ARESETN,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        stat_clear,
  output logic [7:0]  mpeg_data,
  output logic        mpeg_valid,
  output logic        mpeg_sync,
  output logic        locked,
  output logic        pkt_len_204,
  output logic [31:0] packet_count,
  output logic [15:0] sync_loss_count
);

`ifdef TS_ALIGN_204_EN
  localparam logic RS_EN = 1'b1;
`else
  localparam logic RS_EN = 1'b0;
`endif

  ts_state_t  state, state_nxt;
  logic [7:0] byte_cnt, byte_cnt_nxt;
  logic [7:0] good_cnt, good_nxt;
  logic [7:0] bad_cnt, bad_nxt;
  logic       len_204, len_204_nxt;
  logic       len_fixed, len_fixed_nxt;
  logic [7:0] pkt_last;
  logic       in_sync, at_188, at_204;
  logic       fwd, fwd_sync, loss;

  assign in_sync  = is_sync(in_data);
  assign pkt_last = len_204 ? (PACK_RS_BYTE_SIZE - 8'd1) : (PACK_BYTE_SIZE - 8'd1);
  // In VERIFY byte_cnt counts bytes since the last sync, so a candidate sits at count==length
  assign at_188   = (byte_cnt == PACK_BYTE_SIZE) && !(len_fixed && len_204);
  assign at_204   = RS_EN && (byte_cnt == PACK_RS_BYTE_SIZE);

  // Next-state, framing counters and forwarding decision for the accepted byte
  always_comb begin
    state_nxt     = state;
    byte_cnt_nxt  = byte_cnt;
    good_nxt      = good_cnt;
    bad_nxt       = bad_cnt;
    len_204_nxt   = len_204;
    len_fixed_nxt = len_fixed;
    fwd           = 1'b0;
    fwd_sync      = 1'b0;
    loss          = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (in_sync) begin
            state_nxt    = VERIFY;
            byte_cnt_nxt = 8'd1;
            good_nxt     = 8'd0;
          end else begin
            byte_cnt_nxt = 8'd0;
          end
        end
        VERIFY: begin
          if (at_188 || at_204) begin
            if (in_sync) begin
              len_fixed_nxt = 1'b1;
              len_204_nxt   = at_204;
              byte_cnt_nxt  = 8'd1;
              good_nxt      = good_cnt + 8'd1;
              if (good_cnt == 8'(LOCK_COUNT - 1)) begin
                state_nxt = LOCKED;
                bad_nxt   = 8'd0;
                fwd       = 1'b1;
                fwd_sync  = 1'b1;
              end else begin
                state_nxt = VERIFY;
              end
            end else if (at_188 && RS_EN && !len_fixed) begin
              // Length still open: no sync at 188, keep counting toward 204
              byte_cnt_nxt = byte_cnt + 8'd1;
            end else begin
              state_nxt     = HUNT;
              byte_cnt_nxt  = 8'd0;
              good_nxt      = 8'd0;
              len_fixed_nxt = 1'b0;
              len_204_nxt   = 1'b0;
            end
          end else begin
            byte_cnt_nxt = byte_cnt + 8'd1;
          end
        end
        LOCKED: begin
          byte_cnt_nxt = (byte_cnt == pkt_last) ? 8'd0 : (byte_cnt + 8'd1);
          if (byte_cnt == 8'd0) begin
            if (in_sync) begin
              bad_nxt  = 8'd0;
              fwd      = 1'b1;
              fwd_sync = 1'b1;
            end else if (bad_cnt == 8'(UNLOCK_COUNT - 1)) begin
              state_nxt     = HUNT;
              loss          = 1'b1;
              byte_cnt_nxt  = 8'd0;
              bad_nxt       = 8'd0;
              good_nxt      = 8'd0;
              len_fixed_nxt = 1'b0;
              len_204_nxt   = 1'b0;
            end else begin
              // Flywheel: mark the boundary even though the sync byte is wrong
              bad_nxt  = bad_cnt + 8'd1;
              fwd      = 1'b1;
              fwd_sync = 1'b1;
            end
          end else begin
            fwd = (byte_cnt < PACK_BYTE_SIZE);
          end
        end
        default: begin
          state_nxt     = HUNT;
          byte_cnt_nxt  = 8'd0;
          good_nxt      = 8'd0;
          bad_nxt       = 8'd0;
          len_fixed_nxt = 1'b0;
          len_204_nxt   = 1'b0;
        end
      endcase
    end else begin
      state_nxt = state;
    end
  end

  // FSM state and framing counters
  always_ff @(posedge mpeg_clk or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state     <= HUNT;
      byte_cnt  <= 8'd0;
      good_cnt  <= 8'd0;
      bad_cnt   <= 8'd0;
      len_204   <= 1'b0;
      len_fixed <= 1'b0;
    end else begin
      state     <= state_nxt;
      byte_cnt  <= byte_cnt_nxt;
      good_cnt  <= good_nxt;
      bad_cnt   <= bad_nxt;
      len_204   <= len_204_nxt;
      len_fixed <= len_fixed_nxt;
    end
  end

  // Registered output bus; data holds between valid bytes
  always_ff @(posedge mpeg_clk or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      mpeg_data  <= 8'd0;
      mpeg_valid <= 1'b0;
      mpeg_sync  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      mpeg_data  <= fwd ? in_data : mpeg_data;
      mpeg_valid <= fwd;
      mpeg_sync  <= fwd_sync;
      locked     <= (state_nxt == LOCKED);
    end
  end

`ifdef TS_ALIGN_204_EN
  // Length flag reported only for a locked stream
  always_ff @(posedge mpeg_clk or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      pkt_len_204 <= 1'b0;
    end else begin
      pkt_len_204 <= len_204_nxt && (state_nxt == LOCKED);
    end
  end
`else
  assign pkt_len_204 = 1'b0;
`endif

  ts_align_stats u_stats (
    .clk             (mpeg_clk),
    .rst_n           (S_AXI_ARESETN),
    .clear           (stat_clear),
    .pkt_inc         (fwd_sync),
    .loss_inc        (loss),
    .packet_count    (packet_count),
    .sync_loss_count (sync_loss_count)
  );

endmodule

// File: tb/tb_ts_packet_aligner.sv
// Bench for ts_packet_aligner: randomized framed streams checked every cycle against an
// offset-based behavioural model, plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_ts_packet_aligner;

`ifdef TS_ALIGN_204_EN
  localparam bit EN204 = 1'b1;
`else
  localparam bit EN204 = 1'b0;
`endif

  logic        mpeg_clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        stat_clear;
  logic [7:0]  mpeg_data;
  logic        mpeg_valid, mpeg_sync, locked, pkt_len_204;
  logic [31:0] packet_count;
  logic [15:0] sync_loss_count;

  logic        s_rst_n, s_clear, s_pkt, s_loss;
  logic [31:0] s_pc;
  logic [15:0] s_sl;

  always #5 mpeg_clk = ~mpeg_clk;

  ts_packet_aligner dut (
    .mpeg_clk(mpeg_clk), .S_AXI_ARESETN(rst_n), .in_data(in_data), .in_valid(in_valid),
    .stat_clear(stat_clear), .mpeg_data(mpeg_data), .mpeg_valid(mpeg_valid),
    .mpeg_sync(mpeg_sync), .locked(locked), .pkt_len_204(pkt_len_204),
    .packet_count(packet_count), .sync_loss_count(sync_loss_count)
  );

  ts_align_stats u_sat (
    .clk(mpeg_clk), .rst_n(s_rst_n), .clear(s_clear), .pkt_inc(s_pkt), .loss_inc(s_loss),
    .packet_count(s_pc), .sync_loss_count(s_sl)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_sync   = 0;
  bit chk_en   = 1'b0;
  bit sat_done = 1'b0;

  // Model: mode 0 hunt, 1 verify, 2 locked; positions are offsets from the last confirmed sync
  int m_mode, m_idx, m_anchor, m_plen, m_good, m_bad;
  logic [7:0]  e_data;
  bit          e_valid, e_sync, e_locked, e_len204;
  logic [31:0] e_pc;
  logic [15:0] e_sl;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_anchor = 0; m_plen = 0; m_good = 0; m_bad = 0;
    e_data = 8'd0; e_valid = 0; e_sync = 0; e_locked = 0; e_len204 = 0;
    e_pc = 32'd0; e_sl = 16'd0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit clr);
    int off, hit;
    bit fail, lost;
    e_valid = 0; e_sync = 0; lost = 0;
    if (v) begin
      m_idx++;
      off = m_idx - m_anchor;
      hit = 0; fail = 0;
      case (m_mode)
        0: if (d == 8'h47) begin m_mode = 1; m_anchor = m_idx; m_plen = 0; m_good = 0; end
        1: begin
          if (m_plen != 0) begin
            if (off == m_plen) begin if (d == 8'h47) hit = m_plen; else fail = 1; end
          end else if (off == 188) begin
            if (d == 8'h47) hit = 188; else if (!EN204) fail = 1;
          end else if (off == 204) begin
            if (d == 8'h47) hit = 204; else fail = 1;
          end
          if (fail) m_mode = 0;
          if (hit != 0) begin
            m_plen = hit; m_anchor = m_idx; m_good++;
            if (m_good == 3) begin
              m_mode = 2; m_bad = 0; e_valid = 1; e_sync = 1; e_data = d;
            end
          end
        end
        default: begin
          off = off % m_plen;
          if (off == 0) begin
            if (d == 8'h47) begin m_bad = 0; e_valid = 1; e_sync = 1; e_data = d; end
            else if (m_bad == 2) begin m_mode = 0; lost = 1; end
            else begin m_bad++; e_valid = 1; e_sync = 1; e_data = d; end
          end else if (off < 188) begin
            e_valid = 1; e_data = d;
          end
        end
      endcase
    end
    if (clr) begin
      e_pc = 32'd0; e_sl = 16'd0;
    end else begin
      if (e_sync) e_pc++;
      if (lost && e_sl != 16'hFFFF) e_sl++;
    end
    e_locked = (m_mode == 2);
    e_len204 = (m_mode == 2) && (m_plen == 204);
  endtask

  // Per-cycle comparison of every DUT output against the model
  always @(negedge mpeg_clk) begin
    if (chk_en) begin
      check("mpeg_valid", mpeg_valid, e_valid);
      check("mpeg_data", mpeg_data, e_data);
      check("mpeg_sync", mpeg_sync, e_sync);
      check("locked", locked, e_locked);
      check("pkt_len_204", pkt_len_204, e_len204);
      check("packet_count", packet_count, e_pc);
      check("sync_loss_count", sync_loss_count, e_sl);
      if (mpeg_valid) begin
        n_valid++;
        if (mpeg_sync) n_sync++;
      end
    end
  end

  task automatic step(input bit v, input logic [7:0] d, input bit clr);
    @(negedge mpeg_clk); #1;
    in_valid = v; in_data = d; stat_clear = clr;
    model_step(v, d, clr);
  endtask

  function automatic logic [7:0] payload();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == 8'h47) b = 8'h46;
    return b;
  endfunction

  task automatic send_pkt(input int len, input logic [7:0] sync_b, input int gap_pct,
                          input bit clr_sync, input bit wild);
    logic [7:0] b;
    bit c;
    for (int i = 0; i < len; i++) begin
      while ($urandom_range(0, 99) < gap_pct) step(1'b0, 8'($urandom_range(0, 255)), 1'b0);
      b = (i == 0) ? sync_b : (wild ? 8'($urandom_range(0, 255)) : payload());
      c = ((i == 0) && clr_sync) || (wild && ($urandom_range(0, 99) == 0));
      step(1'b1, b, c);
    end
  endtask

  task automatic settle();
    step(1'b0, 8'h00, 1'b0);
    @(negedge mpeg_clk); #2;
  endtask

  task automatic do_reset(input bit pre_valid);
    @(negedge mpeg_clk); #2;
    if (pre_valid) check("pre_rst_valid", mpeg_valid, 1);
    rst_n = 1'b0; in_valid = 1'b0; stat_clear = 1'b0;
    #1;
    check("rst_mpeg_valid", mpeg_valid, 0);
    check("rst_mpeg_sync", mpeg_sync, 0);
    check("rst_mpeg_data", mpeg_data, 0);
    check("rst_locked", locked, 0);
    check("rst_pkt_len_204", pkt_len_204, 0);
    check("rst_packet_count", packet_count, 0);
    check("rst_sync_loss", sync_loss_count, 0);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  // Stand-alone statistics instance driven to saturation in parallel with the main run
  initial begin
    s_rst_n = 1'b0; s_clear = 1'b0; s_pkt = 1'b0; s_loss = 1'b0;
    repeat (2) @(negedge mpeg_clk);
    #1 s_rst_n = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      @(negedge mpeg_clk);
      if (i == 65534) check("sat_below", s_sl, 16'hFFFE);
      if (i == 65535) check("sat_reach", s_sl, 16'hFFFF);
      #1; s_loss = 1'b1; s_pkt = i[0];
    end
    @(negedge mpeg_clk); #1; s_loss = 1'b0; s_pkt = 1'b0;
    @(negedge mpeg_clk); #2;
    check("sat_hold", s_sl, 16'hFFFF);
    check("sat_pkt_count", s_pc, 32770);
    sat_done = 1'b1;
  end

  initial begin
    int plen;
    logic [7:0] sb;
    plen = EN204 ? 204 : 188;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; stat_clear = 1'b0;
    model_reset();
    repeat (3) @(negedge mpeg_clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge mpeg_clk); #2;
    check("init_locked", locked, 0);
    check("init_packet_count", packet_count, 0);

    // Garbage with a false sync at offset 20, then clean 188-byte packets
    n_valid = 0; n_sync = 0;
    for (int i = 0; i < 50; i++) step(1'b1, (i == 20) ? 8'h47 : payload(), 1'b0);
    for (int p = 0; p < 14; p++) send_pkt(188, 8'h47, 0, 1'b0, 1'b0);
    settle();
    check("A_valid_bytes", n_valid, 1880);
    check("A_syncs", n_sync, 10);
    check("A_packet_count", packet_count, 10);
    check("A_locked", locked, 1);

    // Three corrupted sync bytes in a row: flywheel twice, lose lock on the third
    n_valid = 0; n_sync = 0;
    for (int p = 0; p < 3; p++) send_pkt(188, 8'h00, 0, 1'b0, 1'b0);
    settle();
    check("B_valid_bytes", n_valid, 376);
    check("B_syncs", n_sync, 2);
    check("B_locked", locked, 0);
    check("B_sync_loss", sync_loss_count, 1);
    check("B_packet_count", packet_count, 12);

    // Half-duty in_valid over 23 packets: lock on the 4th, 20 forwarded
    n_valid = 0; n_sync = 0;
    for (int p = 0; p < 23; p++) send_pkt(188, 8'h47, 50, 1'b0, 1'b0);
    settle();
    check("C_valid_bytes", n_valid, 3760);
    check("C_syncs", n_sync, 20);
    check("C_packet_count", packet_count, 32);

    // Clear coinciding with a packet_count increment
    send_pkt(188, 8'h47, 0, 1'b1, 1'b0);
    settle();
    check("D_clr_packet_count", packet_count, 0);
    check("D_clr_sync_loss", sync_loss_count, 0);
    send_pkt(188, 8'h47, 0, 1'b0, 1'b0);
    settle();
    check("D_after_clr_count", packet_count, 1);

    if (EN204) begin
      do_reset(1'b0);
      n_valid = 0; n_sync = 0;
      for (int p = 0; p < 6; p++) send_pkt(204, 8'h47, 10, 1'b0, 1'b0);
      settle();
      check("E_len_204", pkt_len_204, 1);
      check("E_valid_bytes", n_valid, 564);
      check("E_syncs", n_sync, 3);
    end

    // Reset at byte 100 of a locked packet, then re-hunt
    for (int i = 0; i < 100; i++) step(1'b1, (i == 0) ? 8'h47 : payload(), 1'b0);
    do_reset(1'b1);
    n_valid = 0; n_sync = 0;
    for (int p = 0; p < 5; p++) send_pkt(plen, 8'h47, 0, 1'b0, 1'b0);
    settle();
    check("F_relock", locked, 1);
    check("F_valid_bytes", n_valid, 376);
    check("F_packet_count", packet_count, 2);

    // Free-running random stream: corrupt syncs, raw payload, bursts, random clears
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 40)); k++)
          step(1'b1, ($urandom_range(0, 3) == 0) ? 8'h47 : payload(), 1'b0);
      end
      sb = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'h47;
      send_pkt(188, sb, 25, 1'b0, 1'b1);
    end
    settle();

    wait (sat_done);
    settle();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
